// File: rtl/input_sync_bank.sv
// input_sync_bank: per-channel flop-chain synchroniser with rise/fall pulses.
// Define INPUT_SYNC_FILTER_EN to add the per-channel glitch filter.
module input_sync_bank #(
  parameter int unsigned      WIDTH      = 2,
  parameter int unsigned      STAGES     = 2,
  parameter int unsigned      FILTER_LEN = 4,
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  (* keep *) logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_last;
  logic [WIDTH-1:0] out_cur;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  // Synchroniser chain, reset to RESET_VAL so idle inputs give no pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= RESET_VAL;
      end
    end else begin
      sync_q[0] <= in;
      for (int k = 1; k < STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_last = sync_q[STAGES-1];

`ifdef INPUT_SYNC_FILTER_EN
  localparam int unsigned CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CntLast = CW'(FILTER_LEN - 1);

  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] out_q;

  // Adopt the synced level once it has differed for FILTER_LEN cycles
  always_comb begin
    out_d = out_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_last[i] != out_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          out_d[i] = sync_last[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Filter state; reset drops any pending change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= RESET_VAL;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      out_q <= out_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign out_cur = out_q;
`else
  localparam int unsigned unused_filter_len = FILTER_LEN;

  assign out_d   = sync_q[STAGES-2];
  assign out_cur = sync_last;
`endif

  // Pulses compare the level out is about to take with its present level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= out_d & ~out_cur;
      fall_q <= ~out_d & out_cur;
    end
  end

  assign out  = out_cur;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule
